// File: rtl/dcache_assoc.sv
// Set-associative write-back data cache with tree-PLRU replacement.
// Optional uncached bypass path is enabled with macro DCACHE_UNCACHED_EN.
package dcache_assoc_pkg;
  typedef logic [2:0] msize_t;
  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;

  // Burst length encoded as beats-1
  typedef logic [3:0] mlen_t;
  localparam mlen_t MLEN1  = 4'd0;
  localparam mlen_t MLEN2  = 4'd1;
  localparam mlen_t MLEN4  = 4'd3;
  localparam mlen_t MLEN8  = 4'd7;
  localparam mlen_t MLEN16 = 4'd15;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    mlen_t       len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module dcache_assoc
  import dcache_assoc_pkg::*;
#(
  parameter int WAYS       = 4,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  input  logic       d_uncached,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(SETS);
  localparam int TW = 32 - IW - OW - 2;
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WRITEBACK, REFILL
`ifdef DCACHE_UNCACHED_EN
    , UNCACHED
`endif
  } state_t;

  state_t          state;
  dbus_req_t       req;
  logic [WW-1:0]   vway;
  logic [OW-1:0]   beat;
  logic [TW-1:0]   tags     [WAYS][SETS];
  logic [WAYS-1:0] valid    [SETS];
  logic [WAYS-1:0] dirty    [SETS];
  logic [31:0]     data_mem [WAYS][SETS][LINE_WORDS];
`ifdef DCACHE_UNCACHED_EN
  logic            req_unc;
`endif

  logic [TW-1:0] tag;
  logic [IW-1:0] idx;
  logic [OW-1:0] off;
  logic          hit, lookup_hit, inv_found;
  logic [WW-1:0] hit_way, inv_way, plru_way, victim;
  logic [31:0]   hit_word, wb_word;
  logic          unused_bits;

  assign tag      = req.addr[31 -: TW];
  assign idx      = req.addr[OW+2 +: IW];
  assign off      = req.addr[2 +: OW];
  assign hit_word = data_mem[hit_way][idx][off];
  assign wb_word  = data_mem[vway][idx][beat];
  assign victim   = inv_found ? inv_way : plru_way;
  assign unused_bits = ^{req.valid, req.addr[1:0], req.size, d_uncached};

`ifdef DCACHE_UNCACHED_EN
  assign lookup_hit = hit && !req_unc;
`else
  assign lookup_hit = hit;
`endif

  // Tag compare across ways and lowest-numbered invalid way search
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid[idx][w] && tags[w][idx] == tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!inv_found && !valid[idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WW'(w);
      end
    end
  end

  if (WAYS > 1) begin : g_plru
    logic [WAYS-2:0] plru [SETS];
    logic [WAYS-2:0] plru_next;

    // Walk the tree to the LRU leaf, and compute the row pointing away from the hit way
    always_comb begin
      int unsigned node;
      node = 1;
      for (int unsigned l = 0; l < WW; l++)
        node = 2 * node + int'(plru[idx][node-1]);
      plru_way = WW'(node - WAYS);
      plru_next = plru[idx];
      node = 1;
      for (int unsigned l = 0; l < WW; l++) begin
        plru_next[node-1] = ~hit_way[WW-1-l];
        node = 2 * node + int'(hit_way[WW-1-l]);
      end
    end

    // PLRU state: cleared on reset, updated on every lookup hit
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int unsigned s = 0; s < SETS; s++) plru[s] <= '0;
      end else if (state == LOOKUP && lookup_hit) begin
        plru[idx] <= plru_next;
      end
    end
  end else begin : g_dm
    assign plru_way = '0;
  end

  // Line data storage: byte-merge on write hits, beat fill on refill
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == LOOKUP && lookup_hit) begin
        for (int unsigned b = 0; b < 4; b++)
          if (req.strobe[b]) data_mem[hit_way][idx][off][8*b +: 8] <= req.data[8*b +: 8];
      end
      if (state == REFILL && cresp.ready) data_mem[vway][idx][beat] <= cresp.data;
    end
  end

  // Controller FSM with line metadata
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      req   <= '0;
      vway  <= '0;
      beat  <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
      end
`ifdef DCACHE_UNCACHED_EN
      req_unc <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (dreq.valid) begin
          req   <= dreq;
          state <= LOOKUP;
`ifdef DCACHE_UNCACHED_EN
          req_unc <= d_uncached;
`endif
        end
        LOOKUP: begin
          if (lookup_hit) begin
            if (|req.strobe) dirty[idx][hit_way] <= 1'b1;
            state <= IDLE;
          end
`ifdef DCACHE_UNCACHED_EN
          else if (req_unc) state <= UNCACHED;
`endif
          else begin
            vway  <= victim;
            beat  <= '0;
            state <= dirty[idx][victim] ? WRITEBACK : REFILL;
          end
        end
        WRITEBACK: if (cresp.ready) begin
          beat <= beat + 1'b1;
          if (cresp.last) begin
            beat  <= '0;
            state <= REFILL;
          end
        end
        REFILL: if (cresp.ready) begin
          beat <= beat + 1'b1;
          if (cresp.last) begin
            beat              <= '0;
            valid[idx][vway]  <= 1'b1;
            dirty[idx][vway]  <= 1'b0;
            tags[vway][idx]   <= tag;
            state             <= LOOKUP;
          end
        end
`ifdef DCACHE_UNCACHED_EN
        UNCACHED: if (cresp.ready && cresp.last) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Bus outputs decoded from the current state
  always_comb begin
    dresp = '0;
    creq  = '0;
    case (state)
      IDLE: dresp.addr_ok = dreq.valid;
      LOOKUP: if (lookup_hit) begin
        dresp.data_ok = 1'b1;
        dresp.data    = hit_word;
      end
      WRITEBACK: begin
        creq.valid    = 1'b1;
        creq.is_write = 1'b1;
        creq.size     = MSIZE4;
        creq.addr     = {tags[vway][idx], idx, {(OW+2){1'b0}}};
        creq.strobe   = 4'hf;
        creq.data     = wb_word;
        creq.len      = mlen_t'(LINE_WORDS - 1);
      end
      REFILL: begin
        creq.valid = 1'b1;
        creq.size  = MSIZE4;
        creq.addr  = {tag, idx, {(OW+2){1'b0}}};
        creq.len   = mlen_t'(LINE_WORDS - 1);
      end
`ifdef DCACHE_UNCACHED_EN
      UNCACHED: begin
        creq.valid    = 1'b1;
        creq.is_write = |req.strobe;
        creq.size     = req.size;
        creq.addr     = req.addr;
        creq.strobe   = req.strobe;
        creq.data     = req.data;
        creq.len      = MLEN1;
        if (cresp.ready && cresp.last) begin
          dresp.data_ok = 1'b1;
          dresp.data    = cresp.data;
        end
      end
`endif
      default: ;
    endcase
  end
endmodule
